// File: rtl/ooo_fetch_buffer.sv
// Fetch-to-decode instruction queue: a circular buffer of fetch packets with
// first-word fall-through head outputs and a synchronous flush for redirects.
module ooo_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_pc4,
  input  logic [31:0]      enq_instr,
  input  logic             enq_prediction,
  input  logic             enq_mal_insn,
  input  logic             enq_fault_insn,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_pc4,
  output logic [31:0]      deq_instr,
  output logic             deq_prediction,
  output logic             deq_mal_insn,
  output logic             deq_fault_insn,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_pc4   [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic             r_pred  [DEPTH];
  logic             r_mal   [DEPTH];
  logic             r_fault [DEPTH];

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_enqFire;
  logic             w_deqFire;

  // Ready depends only on registered occupancy, so a full buffer stays closed
  // even when decode drains the head in the same cycle.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_enqFire = enq_valid & ~w_full & ~flush;
  assign w_deqFire = ~w_empty & deq_ready & ~flush;

  assign enq_ready = ~w_full;
  assign deq_valid = ~w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;

  // Empty buffer presents an all-zero head so stale packets never leak out.
  assign deq_pc         = w_empty ? 32'h0 : r_pc[r_rptr];
  assign deq_pc4        = w_empty ? 32'h0 : r_pc4[r_rptr];
  assign deq_instr      = w_empty ? 32'h0 : r_instr[r_rptr];
  assign deq_prediction = w_empty ? 1'b0  : r_pred[r_rptr];
  assign deq_mal_insn   = w_empty ? 1'b0  : r_mal[r_rptr];
  assign deq_fault_insn = w_empty ? 1'b0  : r_fault[r_rptr];

  always_ff @(posedge CLK) begin
    if (w_enqFire) begin
      r_pc[r_wptr]    <= enq_pc;
      r_pc4[r_wptr]   <= enq_pc4;
      r_instr[r_wptr] <= enq_instr;
      r_pred[r_wptr]  <= enq_prediction;
      r_mal[r_wptr]   <= enq_mal_insn;
      r_fault[r_wptr] <= enq_fault_insn;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enqFire) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deqFire) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enqFire, w_deqFire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  countInRange: assert property (@(posedge CLK) disable iff (!nRST) r_count <= CNT_W'(DEPTH));

endmodule
